// File: rtl/seg_disp_arbiter_pkg.sv
// Shared seven-segment definitions: arbiter state encoding, blank pattern, requester count
// and the bit layout of the packed {usr, uid, pwd} requester pattern.
package seg_disp_arbiter_pkg;

   localparam int unsigned NREQ   = 3;
   localparam int unsigned SegW   = 7;
   localparam int unsigned PatW   = 3 * SegW;
   localparam int unsigned UsrLsb = 14;
   localparam int unsigned UidLsb = 7;
   localparam int unsigned PwdLsb = 0;

   // Active-low segments, so all ones turns every segment off.
   localparam logic [SegW-1:0] SegBlank = 7'b1111111;

   typedef enum logic [1:0] {
      StIdle,
      StOwn,
      StGap
   } state_e;

   function automatic logic [1:0] onehot_to_idx(logic [NREQ-1:0] oh);
      logic [1:0] idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (oh[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   // (base + step) mod 3 for base, step in 0..2.
   function automatic logic [1:0] rr_next(logic [1:0] base, logic [1:0] step);
      logic [2:0] s = {1'b0, base} + {1'b0, step};
      return (s >= 3'(NREQ)) ? 2'(s - 3'(NREQ)) : s[1:0];
   endfunction

endpackage

// File: rtl/seg_disp_arbiter_if.sv
// Request/pattern/grant/display bundle between the display requesters and the arbiter.
interface seg_disp_arbiter_if;
   import seg_disp_arbiter_pkg::*;

   logic [NREQ-1:0] req;
   logic [PatW-1:0] pat0;
   logic [PatW-1:0] pat1;
   logic [PatW-1:0] pat2;
   logic [NREQ-1:0] gnt;
   logic [SegW-1:0] seg_usr;
   logic [SegW-1:0] seg_uid;
   logic [SegW-1:0] seg_pwd;
   logic            busy;

   modport master (
      output req, pat0, pat1, pat2,
      input  gnt, seg_usr, seg_uid, seg_pwd, busy
   );

   modport slave (
      input  req, pat0, pat1, pat2,
      output gnt, seg_usr, seg_uid, seg_pwd, busy
   );

endinterface

// File: rtl/seg_disp_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: first set request searching from ptr upward mod 3.
module rr_pick3
   import seg_disp_arbiter_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      ptr,
   output logic [NREQ-1:0] sel,
   output logic            valid
);

   logic [1:0] idx;
   logic       found;

   always_comb begin
      sel   = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = rr_next(ptr, 2'(k));
         if (!found && req[idx]) begin
            sel[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/seg_disp_arbiter.sv
// Arbitrates three display requesters onto one set of seven-segment drivers with a
// minimum hold, pre-emption after MAX_HOLD, and one blank gap cycle between owners.
module seg_disp_arbiter
   import seg_disp_arbiter_pkg::*;
#(
   parameter int unsigned MIN_HOLD = 4,
   parameter int unsigned MAX_HOLD = 1000
) (
   input logic               clk,
   input logic               rst,
   seg_disp_arbiter_if.slave bus
);

   localparam int unsigned CntW = $clog2(MAX_HOLD + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_HOLD);
   localparam logic [CntW-1:0] MinCnt = CntW'(MIN_HOLD - 1);

   state_e          state_q, state_d;
   logic [1:0]      ptr_q, ptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [SegW-1:0] usr_q, usr_d;
   logic [SegW-1:0] uid_q, uid_d;
   logic [SegW-1:0] pwd_q, pwd_d;

   logic [NREQ-1:0] pick_sel;
   logic            pick_valid;
   logic [PatW-1:0] owner_pat;
   logic            owner_req;
   logic            others_req;

   rr_pick3 u_pick (
      .req   (bus.req),
      .ptr   (ptr_q),
      .sel   (pick_sel),
      .valid (pick_valid)
   );

   always_comb begin
      owner_pat = {3{SegBlank}};
      unique case (gnt_q)
         3'b001:  owner_pat = bus.pat0;
         3'b010:  owner_pat = bus.pat1;
         3'b100:  owner_pat = bus.pat2;
         default: owner_pat = {3{SegBlank}};
      endcase
   end

   assign owner_req  = |(bus.req & gnt_q);
   assign others_req = |(bus.req & ~gnt_q);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      usr_d   = SegBlank;
      uid_d   = SegBlank;
      pwd_d   = SegBlank;
      unique case (state_q)
         StIdle: begin
            gnt_d = '0;
            if (pick_valid) begin
               state_d = StOwn;
               gnt_d   = pick_sel;
               ptr_d   = rr_next(onehot_to_idx(pick_sel), 2'd1);
               cnt_d   = '0;
            end
         end
         StOwn: begin
            if (cnt_q != MaxCnt) cnt_d = cnt_q + CntW'(1);
            if ((!owner_req && cnt_q >= MinCnt) || (cnt_q == MaxCnt && others_req)) begin
               state_d = StGap;
               gnt_d   = '0;
            end else begin
               // Displays follow the owner's live pattern with one register of latency.
               usr_d = owner_pat[UsrLsb +: SegW];
               uid_d = owner_pat[UidLsb +: SegW];
               pwd_d = owner_pat[PwdLsb +: SegW];
            end
         end
         StGap: begin
            state_d = StIdle;
            gnt_d   = '0;
         end
         default: begin
            state_d = StIdle;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         usr_q   <= SegBlank;
         uid_q   <= SegBlank;
         pwd_q   <= SegBlank;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         usr_q   <= usr_d;
         uid_q   <= uid_d;
         pwd_q   <= pwd_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.seg_usr = usr_q;
   assign bus.seg_uid = uid_q;
   assign bus.seg_pwd = pwd_q;
   assign bus.busy    = (state_q != StIdle);

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Bench for seg_disp_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_seg_disp_arbiter;

   localparam int MinH = 4;
   localparam int MaxA = 1000;
   localparam int MaxB = 8;
   localparam logic [20:0] Blank = 21'h1FFFFF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   seg_disp_arbiter_if bus_a ();
   seg_disp_arbiter_if bus_b ();

   seg_disp_arbiter #(.MIN_HOLD(MinH), .MAX_HOLD(MaxA)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   seg_disp_arbiter #(.MIN_HOLD(MinH), .MAX_HOLD(MaxB)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   always #5 clk = ~clk;

   // Behavioural model: owner index (-1 = none), gap flag, cycles owned minus one, pointer.
   typedef struct packed {
      int          owner;
      bit          gap;
      int          hold;
      int          ptr;
      logic [20:0] seg;
   } mdl_t;

   localparam mdl_t MdlRst = '{owner: -1, gap: 1'b0, hold: 0, ptr: 0, seg: Blank};

   mdl_t m_a, m_b;

   function automatic mdl_t mdl_step(mdl_t m, logic [2:0] req, logic [20:0] p0,
                                     logic [20:0] p1, logic [20:0] p2, int max_h);
      mdl_t        n = m;
      logic [20:0] pats [3];
      bit          found = 1'b0;
      bit          others, released, preempt;
      pats[0] = p0;
      pats[1] = p1;
      pats[2] = p2;
      n.seg = Blank;
      if (m.gap) begin
         n.gap = 1'b0;
      end else if (m.owner < 0) begin
         for (int k = 0; k < 3; k++) begin
            int c = (m.ptr + k) % 3;
            if (!found && req[c]) begin
               found   = 1'b1;
               n.owner = c;
               n.hold  = 0;
               n.ptr   = (c + 1) % 3;
            end
         end
      end else begin
         others   = (req & ~(3'b001 << m.owner)) != 3'b000;
         released = !req[m.owner] && (m.hold + 1 >= MinH);
         preempt  = (m.hold >= max_h) && others;
         if (released || preempt) begin
            n.owner = -1;
            n.gap   = 1'b1;
         end else begin
            n.seg  = pats[m.owner];
            n.hold = (m.hold < max_h) ? m.hold + 1 : max_h;
         end
      end
      return n;
   endfunction

   function automatic logic [2:0] mdl_gnt(mdl_t m);
      return (m.owner >= 0) ? (3'b001 << m.owner) : 3'b000;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_a <= MdlRst;
         m_b <= MdlRst;
      end else begin
         m_a <= mdl_step(m_a, bus_a.req, bus_a.pat0, bus_a.pat1, bus_a.pat2, MaxA);
         m_b <= mdl_step(m_b, bus_b.req, bus_b.pat0, bus_b.pat1, bus_b.pat2, MaxB);
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b0;
      bus_a.req = '0;
      bus_b.req = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      logic [20:0] s;
      #1 rst = 1'b0;
      #1;
      s = {bus_a.seg_usr, bus_a.seg_uid, bus_a.seg_pwd};
      checks++;
      if (bus_a.gnt !== 3'b000) begin
         errors++; $display("FAIL reset_gnt got=%b want=000", bus_a.gnt);
      end
      checks++;
      if (bus_a.busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy got=%b want=0", bus_a.busy);
      end
      checks++;
      if (s !== Blank) begin
         errors++; $display("FAIL reset_seg got=%h want=%h", s, Blank);
      end
      @(negedge clk);
      rst        = 1'b1;
      bus_a.pat0 = 21'h0;
      bus_a.req  = 3'b001;
      @(negedge clk);
      @(negedge clk);
      s = {bus_a.seg_usr, bus_a.seg_uid, bus_a.seg_pwd};
      checks++;
      if (bus_a.gnt !== 3'b001 || s !== 21'h0) begin
         errors++; $display("FAIL reset_own_setup gnt=%b seg=%h want 001/000000", bus_a.gnt, s);
      end
      #2 rst = 1'b0;
      #1;
      s = {bus_a.seg_usr, bus_a.seg_uid, bus_a.seg_pwd};
      checks++;
      if (bus_a.gnt !== 3'b000 || bus_a.busy !== 1'b0 || s !== Blank) begin
         errors++;
         $display("FAIL reset_async gnt=%b busy=%b seg=%h want 000/0/%h", bus_a.gnt, bus_a.busy,
                  s, Blank);
      end
      @(negedge clk);
      rst       = 1'b1;
      bus_a.req = 3'b111;
      @(negedge clk);
      checks++;
      if (bus_a.gnt !== 3'b001) begin
         errors++; $display("FAIL reset_ptr0 gnt=%b want=001", bus_a.gnt);
      end
      bus_a.req = 3'b000;
   endtask

   task automatic test_single();
      logic [20:0] s;
      do_reset();
      bus_a.pat1 = {7'h40, 7'h79, 7'h24};
      bus_a.req  = 3'b010;
      @(negedge clk);
      s = {bus_a.seg_usr, bus_a.seg_uid, bus_a.seg_pwd};
      checks++;
      if (bus_a.gnt !== 3'b010 || s !== Blank) begin
         errors++; $display("FAIL single_grant gnt=%b seg=%h want 010/%h", bus_a.gnt, s, Blank);
      end
      @(negedge clk);
      s = {bus_a.seg_usr, bus_a.seg_uid, bus_a.seg_pwd};
      checks++;
      if (s !== {7'h40, 7'h79, 7'h24}) begin
         errors++; $display("FAIL single_seg got=%h want=%h", s, {7'h40, 7'h79, 7'h24});
      end
      repeat (8) @(negedge clk);
      bus_a.req = 3'b000;
      @(negedge clk);
      s = {bus_a.seg_usr, bus_a.seg_uid, bus_a.seg_pwd};
      checks++;
      if (bus_a.gnt !== 3'b000 || bus_a.busy !== 1'b1 || s !== Blank) begin
         errors++;
         $display("FAIL single_gap gnt=%b busy=%b seg=%h want 000/1/blank", bus_a.gnt,
                  bus_a.busy, s);
      end
      @(negedge clk);
      checks++;
      if (bus_a.gnt !== 3'b000 || bus_a.busy !== 1'b0) begin
         errors++; $display("FAIL single_idle gnt=%b busy=%b want 000/0", bus_a.gnt, bus_a.busy);
      end
   endtask

   task automatic test_min_hold();
      int n;
      do_reset();
      bus_a.pat0 = 21'($urandom);
      bus_a.req  = 3'b001;
      @(negedge clk);
      bus_a.req = 3'b000;
      n = 0;
      while (bus_a.gnt == 3'b001 && n < 20) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n !== MinH) begin
         errors++; $display("FAIL min_hold cycles got=%0d want=%0d", n, MinH);
      end
      checks++;
      if (bus_a.gnt !== 3'b000 || bus_a.busy !== 1'b1) begin
         errors++; $display("FAIL min_hold_gap gnt=%b busy=%b want 000/1", bus_a.gnt, bus_a.busy);
      end
      @(negedge clk);
      checks++;
      if (bus_a.busy !== 1'b0) begin
         errors++; $display("FAIL min_hold_idle busy=%b want 0", bus_a.busy);
      end
   endtask

   task automatic test_round_robin();
      int order [4] = '{0, 1, 2, 0};
      int n;
      do_reset();
      bus_a.req = 3'b111;
      for (int g = 0; g < 4; g++) begin
         n = 0;
         @(negedge clk);
         while (bus_a.gnt == 3'b000 && n < 20) begin
            n++;
            @(negedge clk);
         end
         checks++;
         if (bus_a.gnt !== (3'b001 << order[g])) begin
            errors++;
            $display("FAIL rr_order grant%0d gnt=%b want=%b", g, bus_a.gnt, 3'b001 << order[g]);
         end
         repeat (4) @(negedge clk);
         bus_a.req = 3'b111 & ~bus_a.gnt;
         @(negedge clk);
         checks++;
         if (bus_a.gnt !== 3'b000 || bus_a.busy !== 1'b1) begin
            errors++;
            $display("FAIL rr_gap grant%0d gnt=%b busy=%b want 000/1", g, bus_a.gnt, bus_a.busy);
         end
         bus_a.req = 3'b111;
      end
      bus_a.req = 3'b000;
   endtask

   task automatic test_preempt();
      int n;
      do_reset();
      bus_b.req = 3'b001;
      @(negedge clk);
      n = 0;
      while (bus_b.gnt == 3'b001 && n < 40) begin
         n++;
         if (n == 3) bus_b.req = 3'b101;
         @(negedge clk);
      end
      checks++;
      if (n !== MaxB + 1) begin
         errors++; $display("FAIL preempt_hold cycles got=%0d want=%0d", n, MaxB + 1);
      end
      checks++;
      if (bus_b.gnt !== 3'b000 || bus_b.busy !== 1'b1) begin
         errors++; $display("FAIL preempt_gap gnt=%b busy=%b want 000/1", bus_b.gnt, bus_b.busy);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus_b.gnt !== 3'b100) begin
         errors++; $display("FAIL preempt_next gnt=%b want=100", bus_b.gnt);
      end
      bus_b.req = 3'b000;
   endtask

   task automatic test_no_preempt();
      int bad = 0;
      do_reset();
      bus_b.req = 3'b010;
      @(negedge clk);
      for (int c = 0; c < 2000; c++) begin
         if (bus_b.gnt != 3'b010) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL no_preempt dropped_cycles got=%0d want=0", bad);
      end
      bus_b.req = 3'b000;
   endtask

   task automatic test_random();
      logic [20:0] sa, sb;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         sa = {bus_a.seg_usr, bus_a.seg_uid, bus_a.seg_pwd};
         sb = {bus_b.seg_usr, bus_b.seg_uid, bus_b.seg_pwd};
         checks++;
         if (bus_a.gnt !== mdl_gnt(m_a)) begin
            errors++; $display("FAIL rand_a_gnt cyc=%0d got=%b want=%b", c, bus_a.gnt, mdl_gnt(m_a));
         end
         checks++;
         if (bus_a.busy !== (m_a.owner >= 0 || m_a.gap)) begin
            errors++; $display("FAIL rand_a_busy cyc=%0d got=%b", c, bus_a.busy);
         end
         checks++;
         if (sa !== m_a.seg) begin
            errors++; $display("FAIL rand_a_seg cyc=%0d got=%h want=%h", c, sa, m_a.seg);
         end
         checks++;
         if (bus_b.gnt !== mdl_gnt(m_b)) begin
            errors++; $display("FAIL rand_b_gnt cyc=%0d got=%b want=%b", c, bus_b.gnt, mdl_gnt(m_b));
         end
         checks++;
         if (bus_b.busy !== (m_b.owner >= 0 || m_b.gap)) begin
            errors++; $display("FAIL rand_b_busy cyc=%0d got=%b", c, bus_b.busy);
         end
         checks++;
         if (sb !== m_b.seg) begin
            errors++; $display("FAIL rand_b_seg cyc=%0d got=%h want=%h", c, sb, m_b.seg);
         end
         if (!rst) rst = 1'b1;
         else if ($urandom_range(0, 399) == 0) rst = 1'b0;
         for (int i = 0; i < 3; i++) begin
            if ($urandom_range(0, 5) == 0) bus_a.req[i] = ~bus_a.req[i];
            if ($urandom_range(0, 5) == 0) bus_b.req[i] = ~bus_b.req[i];
         end
         bus_a.pat0 = 21'($urandom);
         bus_a.pat1 = 21'($urandom);
         bus_a.pat2 = 21'($urandom);
         bus_b.pat0 = 21'($urandom);
         bus_b.pat1 = 21'($urandom);
         bus_b.pat2 = 21'($urandom);
      end
   endtask

   initial begin
      bus_a.req  = '0;
      bus_a.pat0 = '0;
      bus_a.pat1 = '0;
      bus_a.pat2 = '0;
      bus_b.req  = '0;
      bus_b.pat0 = '0;
      bus_b.pat1 = '0;
      bus_b.pat2 = '0;
      test_reset();
      test_single();
      test_min_hold();
      test_round_robin();
      test_preempt();
      test_no_preempt();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg_disp_arbiter.md
SEG_DISP_ARBITER -- requirements
Module: seg_disp_arbiter

Interface
REQ-001 Parameter MIN_HOLD, default 4, minimum cycles a grant is held once issued (legal 1..MAX_HOLD).
REQ-002 Parameter MAX_HOLD, default 1000, cycles after which a grant is pre-empted when another requester waits; counter width SHALL be $clog2(MAX_HOLD+1).
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  3  display requests; bit0 login, bit1 uid entry, bit2 password entry; level-held.
REQ-006 pat0, pat1, pat2  input  21 each  requester patterns {usr[6:0], uid[6:0], pwd[6:0]}, active-low segments.
REQ-007 gnt  output  3  one-hot grant, registered; all zero when no owner.
REQ-008 seg_usr, seg_uid, seg_pwd  output  7 each  registered display drive, active-low; 7'b1111111 = blank.
REQ-009 busy  output  1  high in any state except IDLE.

Function
REQ-010 FSM states SHALL be IDLE, OWN and GAP.
REQ-011 IDLE: displays blank, gnt=0; if any req bit set, select a requester round-robin from ptr and enter OWN next cycle with gnt set to it.
REQ-012 Round-robin: search order ptr, ptr+1, ptr+2 mod 3; on each grant ptr SHALL become granted index + 1 mod 3.
REQ-013 OWN: each cycle seg_usr/seg_uid/seg_pwd SHALL be registered from the owner's pat fields (one cycle latency from pat to segment outputs).
REQ-014 OWN: hold counter resets to 0 on grant and increments each OWN cycle, saturating at MAX_HOLD.
REQ-015 OWN exit on release: owner's req low and counter >= MIN_HOLD-1 -> GAP.
REQ-016 OWN with owner req low before MIN_HOLD: grant and last pattern SHALL be held until MIN_HOLD reached, then -> GAP.
REQ-017 OWN pre-emption: counter == MAX_HOLD and any other req bit high -> GAP even if owner req still high.
REQ-018 OWN with owner req high and no other requester: grant held indefinitely; no pre-emption.
REQ-019 GAP: exactly one cycle, gnt=0, displays blank, busy=1; then -> IDLE, which re-arbitrates the following cycle.
REQ-020 Pre-empted requester keeping req high SHALL be re-granted only after all other waiting requesters via round-robin.
REQ-021 Simultaneous requests in IDLE resolve by round-robin only; no fixed priority.
REQ-022 req changes in GAP SHALL have no effect until IDLE.
REQ-023 gnt SHALL never have more than one bit set; segment outputs never mix fields of two requesters.

Reset
REQ-024 rst low SHALL asynchronously force state IDLE, gnt=0, busy=0, all segment outputs 7'b1111111, ptr=0, counter=0.
REQ-025 Reset assertion mid-OWN SHALL drop grant immediately without GAP; after deassertion arbitration restarts from ptr=0.

Structure
REQ-026 State encoding, blank constant 7'b1111111, NREQ=3 and pattern field offsets SHALL live in a shared package with the other seven-segment blocks.
REQ-027 One sub-module rr_pick3 (combinational 3-way round-robin picker: req, ptr -> one-hot select, valid) SHALL be used; counter and FSM stay in the top.

Verification
REQ-028 Reset: rst low while OWN with pat0=21'h0 -> same-edge-independent outputs 7'h7F, gnt=0; after release ptr=0.
REQ-029 Single request: req=3'b010, pat1={7'h40,7'h79,7'h24} -> gnt=010 next cycle, segs 40/79/24 following cycle; req low after 10 cycles -> one GAP cycle blank, then IDLE.
REQ-030 Min hold: req0 pulsed one cycle -> gnt=001 held exactly MIN_HOLD=4 cycles, then GAP, then IDLE.
REQ-031 Round-robin: req=3'b111 held continuously, owners drop req after 5 cycles and re-raise -> grant order 0,1,2,0 with one GAP between each.
REQ-032 Pre-emption: MAX_HOLD=8, req0 held, req2 raised at cycle 3 -> gnt0 removed after counter reaches 8, GAP, then gnt=100.
REQ-033 No pre-emption alone: req1 held 2000 cycles with MAX_HOLD=8 and no other request -> gnt=010 never drops.
